// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target register bridge.
`timescale 1ns/1ps
package i2c_target_pkg;

    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
    localparam logic [BIT_CNT_W-1:0] LAST_TX_BIT   = 4'd7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_e;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev_addr);
        return (addr_byte[7:1] == dev_addr);
    endfunction

endpackage

// File: rtl/i2c_pin_sync.sv
// Oversamples SCL/SDA into the system clock domain and decodes SCL edges
// plus START/STOP bus conditions from one synchronizer/history pair per pin.
`timescale 1ns/1ps
module i2c_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_level,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;
    logic                   scl_now;
    logic                   sda_now;

    // Next-state of the synchronizer chains and the one-deep history flops.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_now    = scl_sync_q[SYNC_STAGES-1];
        sda_now    = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_now;
        sda_hist_d = sda_now;
    end

    // Synchronizer and history registers; an idle bus (both high) is the reset state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // SDA may only move while SCL is low, so an SDA edge under a stable-high SCL is a bus condition.
    assign scl_rise  = scl_now & ~scl_hist_q;
    assign scl_fall  = ~scl_now & scl_hist_q;
    assign sda_level = sda_now;
    assign start_det = scl_now & scl_hist_q & ~sda_now & sda_hist_q;
    assign stop_det  = scl_now & scl_hist_q & sda_now & ~sda_hist_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target that turns write bursts and auto-incrementing reads into
// single-cycle register-file strobes, driving SDA as an open-drain pull-down.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       busy
);

    import i2c_target_pkg::*;

    logic scl_rise, scl_fall, sda_level, start_det, stop_det;

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           reg_addr_q, reg_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 busy_q, busy_d;
    logic                 rw_q, rw_d;
    logic                 acked_q, acked_d;
    logic                 byte_done;
    logic [7:0]           shift_in;

    i2c_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_level (sda_level),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign byte_done = scl_fall && (bit_cnt_q == BITS_PER_BYTE);
    assign shift_in  = {shift_q[6:0], sda_level};

    // Protocol FSM: bus conditions first, then per-state bit handling on SCL edges.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sda_oe_d   = sda_oe_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        acked_d    = acked_q;

        if (wr_en_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end else begin
            reg_addr_d = reg_addr_q;
        end

        // Read data arrives one cycle after rd_en; mid-read bytes start driving immediately.
        if (rd_en_q) begin
            shift_d  = rd_data;
            sda_oe_d = (state_q == ST_RDATA) ? ~rd_data[7] : sda_oe_q;
        end else begin
            shift_d = shift_q;
        end

        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            acked_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            acked_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    state_d = state_q;
                end
                ST_DEV: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        if (addr_match(shift_q, DEV_ADDR)) begin
                            state_d  = ST_DEV_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            rd_en_d  = shift_q[0];
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_RDATA;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = ST_REG;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_REG: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b1;
                        state_d    = ST_REG_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        wr_data_d = shift_q;
                        wr_en_d   = 1'b1;
                        sda_oe_d  = 1'b1;
                        state_d   = ST_WDATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == LAST_TX_BIT) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_level == NACK) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            acked_d    = 1'b1;
                        end
                    end else if (scl_fall && acked_q) begin
                        rd_en_d   = 1'b1;
                        acked_d   = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_RDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= 8'h00;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            acked_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            sda_oe_q   <= sda_oe_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            acked_q    <= acked_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

- I2C target (responder) that converts bus transactions into single-cycle register-file accesses.
- Sits between the board I2C pins and the FPGA's 8-bit register map.
- Accepts write bursts and random-address reads with auto-increment, driving SDA open-drain.
- Synthesizable, clocked by the system clock; SCL and SDA are oversampled, never used as clocks.

## Interface
- DEV_ADDR, 7'h42, 7-bit target address matched after START
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (≥2)
- clk  in  1  system clock; period ≤ 1/4 of the shortest SCL high/low phase
- reset_n  in  1  one clock; reset is synchronous and active-low
- scl_in  in  1  SCL pin level (asynchronous)
- sda_in  in  1  SDA pin level (asynchronous)
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad tri-state, external pull-up)
- reg_addr  out  8  current register address (auto-incrementing)
- wr_data  out  8  write data, valid with wr_en
- wr_en  out  1  one-cycle write strobe
- rd_en  out  1  one-cycle read request for reg_addr
- rd_data  in  8  register read data, valid the cycle after rd_en
- busy  out  1  high from an address-matched START until STOP or return to IDLE

## Operation
- scl_in and sda_in pass through SYNC_STAGES flops plus one history flop, giving scl_rise, scl_fall and the bus conditions below.
- START: SDA falls while SCL is high. It is honoured in every state, including as a repeated start, and enters DEV.
- STOP: SDA rises while SCL is high. It forces IDLE from every state; sda_oe = 0.
- Bits are sampled on scl_rise. sda_oe changes only on scl_fall, except when forced low by STOP or reset.
- FSM states: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- DEV: shift 8 bits.
  - If bits[7:1] ≠ DEV_ADDR, go to IGNORE with no ACK; IGNORE waits for START or STOP.
  - On a match, assert sda_oe on the following scl_fall and go to DEV_ACK.
  - If R/W = 1, rd_en pulses on that same scl_fall.
- DEV_ACK ends on scl_fall after the 9th clock. Release SDA, then:
  - W goes to REG.
  - R goes to RDATA: load the shift register with rd_data and drive bit 7 (sda_oe = ~bit).
- REG: shift 8 bits, then ACK. reg_addr is loaded at the ACK scl_fall. Go to REG_ACK, then WDATA.
- WDATA: shift 8 bits. At the 8th-bit scl_fall:
  - wr_data is set to the shifted byte.
  - wr_en pulses for 1 cycle with the current reg_addr.
  - ACK is driven and the state goes to WDATA_ACK.
  - reg_addr increments one cycle after wr_en.
- RDATA: shift out 8 bits MSB-first, one bit per scl_fall. Release SDA after bit 0, then go to RDATA_ACK.
- RDATA_ACK samples master ACK on scl_rise.
  - ACK (0): reg_addr += 1, rd_en pulses at the next scl_fall, and the next byte loads one cycle later.
  - NACK (1): release SDA and go to IDLE.
- reg_addr wraps 8'hFF → 8'h00. reg_addr persists across transactions, so write-address-then-STOP-then-read works.

## Timing
- Reset values: sda_oe = 0, reg_addr = 0, wr_data = 0, wr_en = 0, rd_en = 0, busy = 0, state = IDLE, synchronizers = 1.
- Pin-to-detect latency is SYNC_STAGES + 1 clk. Every SDA update lands within SYNC_STAGES + 2 clk of the SCL falling pin edge.
- rd_data is captured exactly 1 clk after rd_en.
- Partial bytes:
  - STOP or START mid-byte discards the partial byte; no wr_en is issued.
  - A wr_en already issued stands.
- Reset asserted mid-transaction: all outputs return to reset values on the next clk edge, and SDA is released immediately.
- If STOP and scl_fall are detected in the same cycle, STOP wins.

## Structure
- Package i2c_target_pkg holds the FSM state enum, the bit-count width (4) and the ACK/NACK constants.
- Sub-module i2c_pin_sync (synchronizer plus edge/START/STOP detect) is instantiated once and shared by SCL and SDA.
- The FSM, shift register and address counter live in the top module.

## Test plan
- Write burst:
  - Stimulus: START, 0x84, reg 0x10, data A5 5A C3, STOP.
  - Response: wr_en at addresses 0x10/0x11/0x12 with data A5/5A/C3, and 5 ACKs.
- Read 2 bytes:
  - Stimulus: write reg 0x20, STOP; START 0x85; regfile returns 0x3C, 0x96; master ACKs then NACKs.
  - Response: the bus sees 3C, 96; rd_en occurs twice; state ends in IDLE.
- Address mismatch:
  - Stimulus: START 0x86, data bytes, STOP.
  - Response: sda_oe stays 0 throughout; no wr_en or rd_en.
- Wrap:
  - Stimulus: write to reg 0xFF, data 11 22.
  - Response: wr_en at 0xFF then 0x00.
- STOP after 4 bits of the second data byte: only the first byte is written; the next START is recognized normally.
- Reset mid-read:
  - Stimulus: reset_n low for 1 clk while driving a 0 bit.
  - Response: sda_oe = 0 and busy = 0 on the next clk; the next full transaction succeeds.
